// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter for 16 requesters sharing one datapath.
// Optional hold-limit revocation is compiled in with `define ARB_TIMEOUT_EN.
module rr_grant_arbiter #(
  parameter int unsigned N        = 16,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 arb_en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] ptr,
  output logic                 timeout
);

  localparam int unsigned IdxW = $clog2(N);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] sel_idx;
  logic            sel_found;
  logic            owner_req;
  logic            hold_limit;

  assign owner_req = req[idx_q];

  // First set request searching upward from ptr_q, wrapping modulo N.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!sel_found && req[ptr_q + IdxW'(i)]) begin
        sel_found = 1'b1;
        sel_idx   = ptr_q + IdxW'(i);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HoldW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             timeout_q, timeout_d;

  assign hold_limit = (hold_q == HoldW'(MAX_HOLD));

  // Counter restarts at zero on every new grant since it is cleared outside StGrant.
  always_comb begin
    hold_d    = (state_q == StGrant) ? hold_q + 1'b1 : '0;
    timeout_d = (state_q == StGrant) && owner_req && hold_limit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign hold_limit = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (arb_en && sel_found) begin
          state_d = StGrant;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << sel_idx;
          idx_d   = sel_idx;
        end
      end
      StGrant: begin
        // A revocation by the hold limit is handled exactly like a release.
        if (!owner_req || hold_limit) begin
          state_d = StGap;
          gnt_d   = '0;
          idx_d   = '0;
          ptr_d   = idx_q + 1'b1;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == StGrant);
  assign ptr       = ptr_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural round-robin model.
module tb_rr_grant_arbiter;

  localparam int NReq    = 16;
  localparam int MaxHold = 15;
`ifdef ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        arb_en;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic [3:0]  ptr;
  logic        timeout;

  always #5 clk = ~clk;

  rr_grant_arbiter #(
    .N       (NReq),
    .MAX_HOLD(MaxHold)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .arb_en   (arb_en),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .ptr      (ptr),
    .timeout  (timeout)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: owner is the granted requester or -1; gap marks the idle cycle after a release.
  typedef struct {
    int owner;
    bit gap;
    int ptr;
    int hold;
    bit to;
  } mst_t;

  mst_t m;
  bit   m_ok = 1'b0;

  function automatic mst_t step(input mst_t s, input logic rn, input logic en,
                                input logic [15:0] r);
    mst_t n;
    n    = s;
    n.to = 1'b0;
    if (!rn) begin
      n.owner = -1;
      n.gap   = 1'b0;
      n.ptr   = 0;
      n.hold  = 0;
      return n;
    end
    if (s.gap) begin
      n.gap = 1'b0;
    end else if (s.owner < 0) begin
      if (en) begin
        for (int k = 0; k < NReq; k++) begin
          int c;
          c = (s.ptr + k) % NReq;
          if (r[c] && n.owner < 0) begin
            n.owner = c;
            n.hold  = 0;
          end
        end
      end
    end else if (!r[s.owner] || (ToEn && s.hold == MaxHold)) begin
      n.to    = r[s.owner];
      n.ptr   = (s.owner + 1) % NReq;
      n.owner = -1;
      n.gap   = 1'b1;
    end else begin
      n.hold = s.hold + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= step(m, rst_n, arb_en, req);
    if (!rst_n) m_ok <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("model gnt", {16'h0, gnt}, (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0);
      check("model gnt_idx", {28'h0, gnt_idx}, (m.owner >= 0) ? m.owner : 0);
      check("model gnt_valid", {31'h0, gnt_valid}, {31'h0, m.owner >= 0});
      check("model ptr", {28'h0, ptr}, m.ptr);
      check("model timeout", {31'h0, timeout}, {31'h0, m.to});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_grant(input string name, input int exp_idx);
    int t;
    t = 0;
    while (!gnt_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    check({name, " valid"}, {31'h0, gnt_valid}, 32'd1);
    check({name, " idx"}, {28'h0, gnt_idx}, exp_idx);
  endtask

  initial begin
    int held;
    bit seen_to;
    rst_n  = 1'b0;
    req    = 16'hFFFF;
    arb_en = 1'b1;
    cyc(2);
    check("reset gnt", {16'h0, gnt}, 32'd0);
    check("reset valid", {31'h0, gnt_valid}, 32'd0);
    check("reset ptr", {28'h0, ptr}, 32'd0);
    rst_n = 1'b1;
    req   = 16'h0000;
    cyc(2);
    check("idle gnt_idx", {28'h0, gnt_idx}, 32'd0);
    check("idle ptr", {28'h0, ptr}, 32'd0);

    // Single request: one-cycle latency, pointer moves past the owner on release.
    req = 16'h0020;
    cyc(1);
    check("single gnt", {16'h0, gnt}, 32'h0020);
    check("single idx", {28'h0, gnt_idx}, 32'd5);
    req = 16'h0000;
    cyc(1);
    check("single release gnt", {16'h0, gnt}, 32'd0);
    check("single release ptr", {28'h0, ptr}, 32'd6);

    // Search from ptr=6 wraps past 15 to index 0 before reaching 4.
    req = 16'h0011;
    wait_grant("wrap search", 0);
    check("wrap search ptr held", {28'h0, ptr}, 32'd6);
    req = 16'h0000;
    cyc(1);
    check("wrap release ptr", {28'h0, ptr}, 32'd1);
    cyc(1);

    // Rotation between 0 and 15 starting from ptr=0.
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    req   = 16'h8001;
    for (int r = 0; r < 4; r++) begin
      int e;
      e = (r % 2 == 1) ? 15 : 0;
      wait_grant($sformatf("rotation %0d", r), e);
      cyc(2);
      req[e] = 1'b0;
      cyc(1);
      check($sformatf("rotation %0d release ptr", r), {28'h0, ptr}, (e == 15) ? 0 : 1);
      req[e] = 1'b1;
    end
    req = 16'h0000;
    cyc(3);

    // arb_en gating, grant held with arb_en low, reset mid-grant.
    arb_en = 1'b0;
    req    = 16'h0100;
    cyc(3);
    check("gated no grant", {31'h0, gnt_valid}, 32'd0);
    arb_en = 1'b1;
    cyc(1);
    check("enabled grant idx", {28'h0, gnt_idx}, 32'd8);
    check("enabled grant gnt", {16'h0, gnt}, 32'h0100);
    arb_en = 1'b0;
    cyc(3);
    check("grant kept arb_en low", {16'h0, gnt}, 32'h0100);
    rst_n = 1'b0;
    cyc(1);
    check("mid-grant reset gnt", {16'h0, gnt}, 32'd0);
    check("mid-grant reset ptr", {28'h0, ptr}, 32'd0);
    rst_n  = 1'b1;
    arb_en = 1'b1;
    req    = 16'h0000;
    cyc(2);

    // Hold limit: a continuous request of index 2.
    req = 16'h0004;
    wait_grant("hold grant", 2);
    held    = 1;
    seen_to = 1'b0;
    while (gnt_valid && held < 130) begin
      @(negedge clk);
      if (timeout) seen_to = 1'b1;
      if (gnt_valid) held++;
    end
    if (ToEn) begin
      check("hold cycles", held, 32'd16);
      check("timeout pulse", {31'h0, timeout}, 32'd1);
      check("timeout ptr", {28'h0, ptr}, 32'd3);
      check("timeout gnt", {16'h0, gnt}, 32'd0);
      cyc(1);
      check("timeout one cycle", {31'h0, timeout}, 32'd0);
      wait_grant("regrant after timeout", 2);
    end else begin
      check("held 100+ cycles", {31'h0, held >= 100}, 32'd1);
      check("no timeout seen", {31'h0, seen_to}, 32'd0);
    end
    req = 16'h0000;
    cyc(3);

    // Random traffic, occasional reset and arb_en drops.
    req = 16'($urandom);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 16; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      arb_en = ($urandom_range(0, 9) != 0);
      rst_n  = ($urandom_range(0, 199) != 0);
    end
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
